input_debouncer: RTL and testbench
==================================

# input_debouncer

Conditions a raw, asynchronous single-bit input (push-button, switch, external strobe) before it is used by the register and flip-flop stages downstream. It synchronizes the input through a flip-flop chain and filters bounce with a consecutive-sample counter. It presents a clean registered level plus optional one-cycle edge pulses. It sits directly upstream of the team's data/enable flip-flop stages and drives their `d` or enable inputs.

## Interface

- `SYNC_STAGES`, default 2: number of synchronizer flops; legal range ≥ 2.
- `STABLE_CYCLES`, default 1000: consecutive samples that must differ from `dout` before `dout` changes; legal range 1 to 2^CNT_WIDTH − 1.
- `CNT_WIDTH`, default 16: width of the debounce counter.
- `INIT_LEVEL`, default 1'b0: reset value of the synchronizer flops and `dout`.

- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `din`, input, 1: raw asynchronous input.
- `dout`, output, 1: debounced, registered level.
- `rise`, output, 1: one-cycle pulse when `dout` goes 0→1.
- `fall`, output, 1: one-cycle pulse when `dout` goes 1→0.
- `busy`, output, 1: high while a candidate change is being qualified.

## Operation

- Synchronizer: `din` is shifted through `SYNC_STAGES` flops. The last flop is `s`. Only `s` is used by logic.
- FSM with two states:
  - STABLE (reset state), with counter = 0.
  - CHECK.
- In STABLE:
  - If `s == dout`: hold.
  - If `s != dout` and `STABLE_CYCLES == 1`: toggle `dout` on this edge and stay in STABLE.
  - If `s != dout` and `STABLE_CYCLES > 1`: counter ← 1 and go to CHECK.
- In CHECK:
  - If `s == dout` (bounce back): counter ← 0, go to STABLE, `dout` unchanged, no pulse.
  - Else if counter == STABLE_CYCLES − 1: toggle `dout`, counter ← 0, go to STABLE.
  - Else: counter ← counter + 1.
- `busy` = (state == CHECK). It is a registered state decode.
- `rise` is high for exactly the one cycle following the edge on which `dout` changed 0→1. `fall` behaves the same for 1→0. `rise` and `fall` are never high together.
- The counter never exceeds STABLE_CYCLES − 1. There is no wrap-around.
- Reset values:
  - synchronizer flops = INIT_LEVEL
  - `dout` = INIT_LEVEL
  - counter = 0
  - state = STABLE
  - `rise` = `fall` = `busy` = 0
- Reset while in CHECK aborts qualification: no pulse is issued and `dout` returns to INIT_LEVEL. Reset has priority over every other event in the same cycle.
- After reset, if `din` ≠ INIT_LEVEL, the block qualifies the level normally and reports the corresponding edge.

## Timing

- Latency from a clean `din` step to `dout` change is SYNC_STAGES + STABLE_CYCLES rising edges. `rise`/`fall` is asserted in the same cycle as the `dout` change.
- `busy` is high for STABLE_CYCLES − 1 cycles immediately before the `dout` change. With STABLE_CYCLES = 1, `busy` never asserts.
- A `din` pulse whose synchronized width is shorter than STABLE_CYCLES cycles produces no `dout` change.
- Minimum spacing between two reported edges is STABLE_CYCLES cycles.

## Configuration

- Macro: `INPUT_DEBOUNCER_EDGE_EN`.
- Defined: `rise` and `fall` are generated as described above.
- Undefined:
  - The edge-pulse registers are not built.
  - `rise` and `fall` are tied to 0.
  - `dout` and `busy` behaviour is identical.

## Test plan

All scenarios use SYNC_STAGES = 2, STABLE_CYCLES = 4, INIT_LEVEL = 0 and `INPUT_DEBOUNCER_EDGE_EN` defined, unless noted.

- Reset: `rst` = 1 for 2 edges with `din` = 1 → `dout` = 0; `rise`, `fall`, `busy` = 0.
- Clean rise: `din` 0→1 and held → `busy` high after edges 3–5, `dout` = 1 after edge 6, `rise` high for exactly 1 cycle, then `busy` = 0.
- Glitch rejection: `din` = 1 for 3 cycles, then 0 → `busy` pulses, `dout` stays 0, `rise` never asserts.
- Clean fall: from `dout` = 1, `din` 1→0 held → `dout` = 0 six edges later, `fall` is a 1-cycle pulse, `rise` stays 0.
- Reset mid-qualification: `din` → 1, then `rst` = 1 on the edge where `busy` is high → `busy` = 0, counter = 0, `dout` = 0, no `rise`; after `rst` = 0 with `din` still 1, `dout` = 1 exactly 6 edges later.
- Macro undefined: repeat the clean-rise scenario → `dout` and `busy` timing unchanged; `rise` and `fall` stay 0 throughout.

Source files
------------

// File: rtl/input_debouncer.sv
// Two-flop (or deeper) synchronizer followed by a consecutive-sample debounce FSM.
// Optional edge pulses are built only when INPUT_DEBOUNCER_EDGE_EN is defined.
module input_debouncer #(
    parameter int   SYNC_STAGES   = 2,
    parameter int   STABLE_CYCLES = 1000,
    parameter int   CNT_WIDTH     = 16,
    parameter logic INIT_LEVEL    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
);

    typedef enum logic {STABLE, CHECK} state_t;

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam bit SINGLE = (STABLE_CYCLES == 1);

    state_t                 state;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic                   toggle;

    always_ff @(posedge clk) begin
        if (rst) sync <= {SYNC_STAGES{INIT_LEVEL}};
        else     sync <= {sync[SYNC_STAGES-2:0], din};
    end

    assign s = sync[SYNC_STAGES-1];

    // dout flips this edge: immediately when no qualification is needed,
    // otherwise on the last qualifying sample of CHECK.
    always_comb begin
        toggle = 1'b0;
        if (s != dout) begin
            if (state == STABLE) toggle = SINGLE;
            else                 toggle = (cnt == LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= STABLE;
            cnt   <= '0;
            dout  <= INIT_LEVEL;
            busy  <= 1'b0;
        end else begin
            case (state)
                STABLE: begin
                    if (s != dout) begin
                        if (SINGLE) begin
                            dout <= ~dout;
                        end else begin
                            cnt   <= CNT_WIDTH'(1);
                            state <= CHECK;
                            busy  <= 1'b1;
                        end
                    end
                end
                CHECK: begin
                    if (s == dout) begin
                        cnt   <= '0;
                        state <= STABLE;
                        busy  <= 1'b0;
                    end else if (cnt == LAST) begin
                        dout  <= ~dout;
                        cnt   <= '0;
                        state <= STABLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_WIDTH'(1);
                    end
                end
                default: begin
                    state <= STABLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef INPUT_DEBOUNCER_EDGE_EN
    // Pulses line up with the cycle in which the new dout level is visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= toggle & ~dout;
            fall <= toggle &  dout;
        end
    end
`else
    logic unused_toggle;
    assign unused_toggle = toggle;
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer (SYNC_STAGES=2, STABLE_CYCLES=4, INIT_LEVEL=0).
// Edge-pulse expectations follow whether INPUT_DEBOUNCER_EDGE_EN is defined.
module tb_input_debouncer;

`ifdef INPUT_DEBOUNCER_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, din;
    logic dout, rise, fall, busy;
    int   n_checks = 0;
    int   n_fail   = 0;

    input_debouncer #(
        .SYNC_STAGES  (2),
        .STABLE_CYCLES(4),
        .CNT_WIDTH    (16),
        .INIT_LEVEL   (1'b0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .din (din),
        .dout(dout),
        .rise(rise),
        .fall(fall),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        logic [5:0] busy_e, dout_e, fall_dout_e;
        logic [7:0] gl_busy_e;

        // reset with din high
        rst = 1'b1; din = 1'b1;
        step(2);
        chk("rst_dout", dout, 1'b0);
        chk("rst_rise", rise, 1'b0);
        chk("rst_fall", fall, 1'b0);
        chk("rst_busy", busy, 1'b0);

        rst = 1'b0; din = 1'b0;
        step(4);
        chk("idle_dout", dout, 1'b0);

        // clean rise
        busy_e = 6'b011100;
        dout_e = 6'b100000;
        din = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1);
            chk($sformatf("rise_busy_e%0d", i + 1), busy, busy_e[i]);
            chk($sformatf("rise_dout_e%0d", i + 1), dout, dout_e[i]);
            chk($sformatf("rise_rise_e%0d", i + 1), rise, EDGE & dout_e[i]);
            chk($sformatf("rise_fall_e%0d", i + 1), fall, 1'b0);
        end
        step(1);
        chk("rise_pulse_end", rise, 1'b0);
        chk("rise_hold_dout", dout, 1'b1);
        chk("rise_busy_end", busy, 1'b0);

        // clean fall
        fall_dout_e = 6'b011111;
        din = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            chk($sformatf("fall_busy_e%0d", i + 1), busy, busy_e[i]);
            chk($sformatf("fall_dout_e%0d", i + 1), dout, fall_dout_e[i]);
            chk($sformatf("fall_fall_e%0d", i + 1), fall, EDGE & ~fall_dout_e[i] );
            chk($sformatf("fall_rise_e%0d", i + 1), rise, 1'b0);
        end
        step(1);
        chk("fall_pulse_end", fall, 1'b0);
        chk("fall_hold_dout", dout, 1'b0);
        step(2);

        // glitch: din high for 3 cycles only
        gl_busy_e = 8'b00011100;
        din = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) din = 1'b0;
            step(1);
            chk($sformatf("gl_busy_e%0d", i + 1), busy, gl_busy_e[i]);
            chk($sformatf("gl_dout_e%0d", i + 1), dout, 1'b0);
            chk($sformatf("gl_rise_e%0d", i + 1), rise, 1'b0);
        end
        step(2);

        // reset while qualifying
        din = 1'b1;
        step(3);
        chk("mid_busy_pre", busy, 1'b1);
        rst = 1'b1;
        step(1);
        chk("mid_busy_rst", busy, 1'b0);
        chk("mid_dout_rst", dout, 1'b0);
        chk("mid_rise_rst", rise, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            chk($sformatf("mid_dout_e%0d", i + 1), dout, dout_e[i]);
            chk($sformatf("mid_busy_e%0d", i + 1), busy, busy_e[i]);
            chk($sformatf("mid_rise_e%0d", i + 1), rise, EDGE & dout_e[i]);
        end
        step(1);
        chk("mid_rise_end", rise, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no end, expected end of test");
        $fatal(1, "timeout");
    end

endmodule
